wb_trace_fifo: RTL and testbench
================================

// Module: wb_trace_fifo
// PURPOSE
//  Consumer side of the register-file writeback port: captures one trace record per retired
//  instruction (pc, write enable, dest reg, write data) and buffers it in a FIFO.
//  Drains over a valid/ready stream to the trace comparator or the debug UART.
//  Sits beside the register file in the single-cycle core; it never stalls the core.
// PARAMETERS
//  DEPTH   8   FIFO entries; must be a power of two, >= 2
//  AW      3   log2(DEPTH); pointer width without the wrap bit
// PORTS
//  clk          in   1   single clock; all state updates on its rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  flush        in   1   synchronous clear of FIFO contents and counters
//  wb_have_inc  in   1   an instruction retires this cycle; capture request
//  wb_pc        in   32  pc of the retiring instruction
//  wb_we        in   1   register-file write enable of the retiring instruction
//  wb_reg       in   5   destination register index
//  wb_value     in   32  value written (writeback mux output)
//  m_valid      out  1   head record is available
//  m_ready      in   1   sink accepts the head record
//  m_pc         out  32  head record pc
//  m_ena        out  1   head record write enable (already masked for r0)
//  m_reg        out  5   head record dest reg
//  m_value      out  32  head record value
//  level        out  AW+1  occupancy, 0..DEPTH
//  overflow     out  1   sticky: at least one record was dropped
//  drop_cnt     out  16  dropped-record count, saturates at 16'hFFFF
//  retire_cnt   out  32  retired-instruction count, wraps modulo 2^32
// BEHAVIOUR
//  Reset (rst_n=0, async): pointers, level, overflow, drop_cnt, retire_cnt = 0.
//   m_valid = 0. m_pc/m_ena/m_reg/m_value = 0.
//   Storage array contents are not reset.
//  Record format: {pc, ena, reg, value}.
//   ena = wb_we & (wb_reg != 0): writes to r0 are recorded with ena=0, value as presented.
//   reg and value are always recorded.
//  Push = wb_have_inc & ~flush. Pop = m_valid & m_ready & ~flush.
//  Pointers are AW+1 bits (wrap bit). Empty when pointers are equal. Full when the
//   indices are equal and the wrap bits differ. Indices wrap DEPTH-1 -> 0.
//  Latency: a record pushed in cycle N is visible on m_* in cycle N+1 at the earliest.
//   There is no same-cycle bypass. This applies even when the FIFO is empty.
//  m_* is driven from the storage at the read pointer. It is stable while m_valid=1 and
//   m_ready=0. m_valid = ~empty.
//  Push when not full: store at the write pointer and advance it.
//  Push when full with a pop in the same cycle: accepted; level unchanged.
//  Push when full without a pop: record dropped, overflow<=1, drop_cnt+1 (saturating).
//   Storage and pointers are unchanged.
//  Pop and push when not full: both happen; level unchanged.
//  Pop when empty: impossible (m_valid=0); ready is ignored.
//  retire_cnt increments on every wb_have_inc=1 while flush=0, whether or not the record
//   is dropped.
//  flush=1: next edge sets pointers, level, overflow, drop_cnt, retire_cnt to 0.
//   Flush takes priority over push and pop in the same cycle.
//  The asynchronous reset asserted mid-stream discards all records immediately. m_valid
//   falls without waiting for the clock.
// TESTING
//  1 Reset, then push 3 records (pc 0x0,0x4,0x8) with m_ready=0 -> level=3, m_valid=1,
//    m_pc=0x0 held stable. Then m_ready=1 -> pc 0x0,0x4,0x8 on 3 consecutive cycles,
//    then m_valid=0.
//  2 Push wb_we=1, wb_reg=0, wb_value=0xDEAD -> record shows m_ena=0, m_reg=0,
//    m_value=0xDEAD. Push wb_reg=5, we=1 -> m_ena=1.
//  3 m_ready=0, push DEPTH+2 records -> level=DEPTH, overflow=1, drop_cnt=2,
//    retire_cnt=DEPTH+2. Head is the first record; the last two are lost.
//  4 FIFO full, push and pop in the same cycle for 2*DEPTH cycles -> level stays DEPTH,
//    drop_cnt unchanged, records emerge in order across pointer wrap.
//  5 Empty FIFO, push with m_ready=1 -> m_valid=0 in the push cycle, 1 in the next.
//    Record is popped that cycle; level returns to 0.
//  6 Level=5, overflow=1: assert flush with a push -> next cycle level=0, overflow=0,
//    retire_cnt=0. Then drop rst_n mid-drain -> m_valid=0 asynchronously.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures one trace record {pc, ena, reg, value} per retired instruction
// from the register-file writeback port and buffers it for a valid/ready trace sink.
// Never stalls the core: when the buffer is full and nothing drains, the record is dropped
// and counted.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       synchronous clear of contents and counters
//   wb_have_inc, wb_pc, wb_we,
//   wb_reg, wb_value            writeback capture request and record fields
//   m_valid, m_ready            output stream handshake
//   m_pc, m_ena, m_reg, m_value head record (zero while empty)
//   level                       occupancy 0..DEPTH
//   overflow, drop_cnt          sticky drop flag, saturating drop count
//   retire_cnt                  retired-instruction count (wraps)
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wb_have_inc,
  input  logic [31:0]   wb_pc,
  input  logic          wb_we,
  input  logic [4:0]    wb_reg,
  input  logic [31:0]   wb_value,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_pc,
  output logic          m_ena,
  output logic [4:0]    m_reg,
  output logic [31:0]   m_value,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   drop_cnt,
  output logic [31:0]   retire_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] value;
  } rec_t;

  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  rec_t        mem [DEPTH];
  rec_t        head;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        empty, full, push, pop, do_write, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push     = wb_have_inc & ~flush;
  assign pop      = ~empty & m_ready & ~flush;
  // When full, a simultaneous pop frees the slot being written on this same edge.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      overflow_d   = 1'b0;
      drop_cnt_d   = '0;
      retire_cnt_d = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)      rd_ptr_d = rd_ptr_q + PtrOne;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
      if (wb_have_inc) retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q[AW-1:0]] <= '{pc:    wb_pc,
                                 ena:   wb_we & (wb_reg != 5'd0),
                                 rg:    wb_reg,
                                 value: wb_value};
    end
  end

  assign head = mem[rd_ptr_q[AW-1:0]];

  // Head fields are forced to zero while empty so unwritten storage never leaks out.
  always_comb begin
    m_valid = ~empty;
    m_pc    = '0;
    m_ena   = 1'b0;
    m_reg   = '0;
    m_value = '0;
    if (!empty) begin
      m_pc    = head.pc;
      m_ena   = head.ena;
      m_reg   = head.rg;
      m_value = head.value;
    end
  end

  assign level      = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wb_have_inc;
  logic [31:0]   wb_pc;
  logic          wb_we;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_value;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_pc;
  logic          m_ena;
  logic [4:0]    m_reg;
  logic [31:0]   m_value;
  logic [AW:0]   level;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [31:0]   retire_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wb_have_inc (wb_have_inc),
    .wb_pc       (wb_pc),
    .wb_we       (wb_we),
    .wb_reg      (wb_reg),
    .wb_value    (wb_value),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_pc        (m_pc),
    .m_ena       (m_ena),
    .m_reg       (m_reg),
    .m_value     (m_value),
    .level       (level),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wb_have_inc = 1'b0; wb_pc = '0; wb_we = 1'b0;
    wb_reg = '0; wb_value = '0; m_ready = 1'b0;
    #3;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_err++; $display("FAIL reset_retire: got %0d want 0", retire_cnt); end
    n_cmp++; if (m_pc !== 32'd0 || m_value !== 32'd0 || m_ena !== 1'b0 || m_reg !== 5'd0) begin
      n_err++; $display("FAIL reset_head: got pc=%h val=%h want 0", m_pc, m_value);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_have_inc = 1'b1; wb_pc = 32'(4 * i); wb_we = 1'b1; wb_reg = 5'(i + 1);
      wb_value = 32'h1000 + 32'(i);
      step();
    end
    wb_have_inc = 1'b0;
    n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL basic_level: got %0d want 3", level); end
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", m_valid); end
    step();
    n_cmp++; if (m_pc !== 32'h0) begin n_err++; $display("FAIL basic_hold: got %h want 0", m_pc); end
    n_cmp++; if (retire_cnt !== 32'd3) begin n_err++; $display("FAIL basic_retire: got %0d want 3", retire_cnt); end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (m_valid !== 1'b1 || m_pc !== 32'(4 * i)) begin
        n_err++; $display("FAIL basic_drain%0d: got v=%b pc=%h want v=1 pc=%h", i, m_valid, m_pc, 4 * i);
      end
      step();
    end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b want 0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_r0_mask();
    wb_have_inc = 1'b1; wb_pc = 32'h40; wb_we = 1'b1; wb_reg = 5'd0; wb_value = 32'hDEAD;
    step();
    wb_have_inc = 1'b0;
    n_cmp++; if (m_ena !== 1'b0 || m_reg !== 5'd0 || m_value !== 32'hDEAD) begin
      n_err++; $display("FAIL r0_record: got ena=%b reg=%0d val=%h want 0/0/dead", m_ena, m_reg, m_value);
    end
    // Pop the r0 record while pushing the r5 record.
    m_ready = 1'b1; wb_have_inc = 1'b1; wb_pc = 32'h44; wb_reg = 5'd5; wb_value = 32'h1234;
    step();
    wb_have_inc = 1'b0;
    n_cmp++; if (m_ena !== 1'b1 || m_reg !== 5'd5 || m_value !== 32'h1234 || m_pc !== 32'h44) begin
      n_err++; $display("FAIL r5_record: got ena=%b reg=%0d val=%h want 1/5/1234", m_ena, m_reg, m_value);
    end
    step();
    m_ready = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL r0_empty: got %b want 0", m_valid); end
  endtask

  task automatic test_overflow();
    do_flush();
    exp_q.delete();
    m_ready = 1'b0; wb_we = 1'b1; wb_reg = 5'd3;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wb_have_inc = 1'b1; wb_pc = 32'h100 + 32'(4 * i); wb_value = 32'(i);
      if (i < DEPTH) exp_q.push_back(32'h100 + 32'(4 * i));
      step();
    end
    wb_have_inc = 1'b0;
    n_cmp++; if (level !== 4'(DEPTH)) begin n_err++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
    n_cmp++; if (retire_cnt !== 32'(DEPTH + 2)) begin n_err++; $display("FAIL ovf_retire: got %0d want %0d", retire_cnt, DEPTH + 2); end
    n_cmp++; if (m_pc !== 32'h100) begin n_err++; $display("FAIL ovf_head: got %h want 100", m_pc); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      wb_have_inc = 1'b1; wb_pc = 32'h200 + 32'(4 * k);
      #1;
      n_cmp++; if (m_pc !== exp_q[0] || level !== 4'(DEPTH)) begin
        n_err++; $display("FAIL b2b_%0d: got pc=%h lvl=%0d want pc=%h lvl=%0d", k, m_pc, level, exp_q[0], DEPTH);
      end
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h200 + 32'(4 * k));
    end
    wb_have_inc = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_drop: got %0d want 2", drop_cnt); end
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      n_cmp++; if (m_valid !== 1'b1 || m_pc !== exp_q[0]) begin
        n_err++; $display("FAIL b2b_drain%0d: got v=%b pc=%h want pc=%h", k, m_valid, m_pc, exp_q[0]);
      end
      step();
      void'(exp_q.pop_front());
    end
    n_cmp++; if (m_valid !== 1'b0 || level !== 4'd0) begin
      n_err++; $display("FAIL b2b_empty: got v=%b lvl=%0d want 0/0", m_valid, level);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_no_bypass();
    m_ready = 1'b1; wb_have_inc = 1'b1; wb_pc = 32'h300;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL nobyp_same: got %b want 0", m_valid); end
    step();
    wb_have_inc = 1'b0;
    n_cmp++; if (m_valid !== 1'b1 || m_pc !== 32'h300 || level !== 4'd1) begin
      n_err++; $display("FAIL nobyp_next: got v=%b pc=%h lvl=%0d want 1/300/1", m_valid, m_pc, level);
    end
    step();
    n_cmp++; if (m_valid !== 1'b0 || level !== 4'd0) begin
      n_err++; $display("FAIL nobyp_popped: got v=%b lvl=%0d want 0/0", m_valid, level);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_flush_reset();
    do_flush();
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wb_have_inc = 1'b1; wb_pc = 32'h400 + 32'(4 * i);
      step();
    end
    wb_have_inc = 1'b0; m_ready = 1'b1;
    step(); step(); step();
    m_ready = 1'b0;
    n_cmp++; if (level !== 4'd5 || overflow !== 1'b1 || retire_cnt !== 32'(DEPTH + 1)) begin
      n_err++; $display("FAIL pre_flush: got lvl=%0d ovf=%b ret=%0d want 5/1/%0d", level, overflow, retire_cnt, DEPTH + 1);
    end
    n_cmp++; if (m_pc !== 32'h40C) begin n_err++; $display("FAIL pre_flush_head: got %h want 40c", m_pc); end
    flush = 1'b1; wb_have_inc = 1'b1; m_ready = 1'b1;
    step();
    flush = 1'b0; wb_have_inc = 1'b0; m_ready = 1'b0;
    n_cmp++; if (level !== 4'd0 || overflow !== 1'b0 || retire_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
      n_err++; $display("FAIL flush: got lvl=%0d ovf=%b ret=%0d drop=%0d want 0", level, overflow, retire_cnt, drop_cnt);
    end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", m_valid); end
    for (int i = 0; i < 3; i++) begin
      wb_have_inc = 1'b1; wb_pc = 32'h500 + 32'(4 * i);
      step();
    end
    wb_have_inc = 1'b0; m_ready = 1'b1;
    step();
    n_cmp++; if (m_valid !== 1'b1 || m_pc !== 32'h504) begin
      n_err++; $display("FAIL mid_drain: got v=%b pc=%h want 1/504", m_valid, m_pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || level !== 4'd0) begin
      n_err++; $display("FAIL async_reset: got v=%b lvl=%0d want 0/0", m_valid, level);
    end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_err++; $display("FAIL async_retire: got %0d want 0", retire_cnt); end
    m_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_r0_mask();
    test_overflow();
    test_back_to_back();
    test_no_bypass();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
